minmax_tracker: RTL and testbench

- Downstream consumer of the WIDTH-bit unsigned comparator stage. Accepts a stream of samples over a valid/ready handshake and compares each sample against the running max, the running min and the previous sample.
- Accumulates per-frame statistics over FRAME_LEN samples, then holds the results behind an out_valid/out_ready handshake.
- Sits between the datapath operand source and the control/reporting logic.

---
 rtl/minmax_pkg.sv | 10 +
 rtl/minmax_tracker_comp.sv | 16 +
 rtl/minmax_tracker.sv | 101 ++++++++++
 tb/tb_minmax_tracker.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/minmax_pkg.sv
// Shared state encoding for the min/max/trend frame tracker.
package minmax_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/minmax_tracker_comp.sv
// Unsigned magnitude comparator; each flag is a WIDTH-wide bus holding 0 or 1.
module Comp #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] gt,
  output logic [WIDTH-1:0] lt,
  output logic [WIDTH-1:0] eq
);

  assign gt = WIDTH'(a > b);
  assign lt = WIDTH'(a < b);
  assign eq = WIDTH'(a == b);

endmodule

// File: rtl/minmax_tracker.sv
// Per-frame running max/min and rise/fall/equal counts over FRAME_LEN samples,
// with results held behind an out_valid/out_ready handshake.
module minmax_tracker
  import minmax_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = $clog2(FRAME_LEN + 1)
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] max_out,
  output logic [WIDTH-1:0] min_out,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] fall_cnt,
  output logic [CNT_W-1:0] eq_cnt
);

  state_t           state;
  logic [WIDTH-1:0] prev;
  logic [CNT_W-1:0] sample_cnt;

  logic [WIDTH-1:0] max_gt, max_lt, max_eq;
  logic [WIDTH-1:0] min_gt, min_lt, min_eq;
  logic [WIDTH-1:0] prev_gt, prev_lt, prev_eq;

  Comp #(.WIDTH(WIDTH)) u_cmp_max (
    .a (in_data), .b (max_out), .gt (max_gt), .lt (max_lt), .eq (max_eq)
  );

  Comp #(.WIDTH(WIDTH)) u_cmp_min (
    .a (in_data), .b (min_out), .gt (min_gt), .lt (min_lt), .eq (min_eq)
  );

  Comp #(.WIDTH(WIDTH)) u_cmp_prev (
    .a (in_data), .b (prev), .gt (prev_gt), .lt (prev_lt), .eq (prev_eq)
  );

  // Flags not needed for a given compare are folded into a sink on purpose.
  logic unused_flags;
  assign unused_flags = ^{max_lt, max_eq, min_gt, min_eq, prev_eq};

  assign in_ready  = (state != DONE);
  assign out_valid = (state == DONE);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state      <= IDLE;
      max_out    <= '0;
      min_out    <= '0;
      prev       <= '0;
      sample_cnt <= '0;
      rise_cnt   <= '0;
      fall_cnt   <= '0;
      eq_cnt     <= '0;
    end else if (clr || (state == DONE && out_ready) ||
                 !(state inside {IDLE, ACCUM, DONE})) begin
      // Abort, consumed results and illegal encodings all land in a clean IDLE.
      state      <= IDLE;
      max_out    <= '0;
      min_out    <= '0;
      prev       <= '0;
      sample_cnt <= '0;
      rise_cnt   <= '0;
      fall_cnt   <= '0;
      eq_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            max_out    <= in_data;
            min_out    <= in_data;
            prev       <= in_data;
            sample_cnt <= CNT_W'(1);
            state      <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            if (|max_gt) max_out <= in_data;
            if (|min_lt) min_out <= in_data;
            if (|prev_gt)      rise_cnt <= rise_cnt + CNT_W'(1);
            else if (|prev_lt) fall_cnt <= fall_cnt + CNT_W'(1);
            else               eq_cnt   <= eq_cnt + CNT_W'(1);
            prev       <= in_data;
            sample_cnt <= sample_cnt + CNT_W'(1);
            if (sample_cnt == CNT_W'(FRAME_LEN - 1)) state <= DONE;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_minmax_tracker.sv
// Randomized self-checking bench for minmax_tracker with a queue-based frame model.
module tb_minmax_tracker;

  localparam int W = 8;
  localparam int FL = 4;
  localparam int CW = $clog2(FL + 1);

  logic          Clk, Rst, clr, in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0]  in_data, max_out, min_out;
  logic [CW-1:0] rise_cnt, fall_cnt, eq_cnt;

  int checks, errors;
  logic [W-1:0] q[$];
  bit m_done;

  minmax_tracker #(.WIDTH(W), .FRAME_LEN(FL)) dut (
    .Clk(Clk), .Rst(Rst), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .max_out(max_out), .min_out(min_out), .rise_cnt(rise_cnt),
    .fall_cnt(fall_cnt), .eq_cnt(eq_cnt)
  );

  initial Clk = 0;
  always #5 Clk = ~Clk;

  logic [2*W+3*CW+1:0] obs;
  assign obs = {out_valid, in_ready, max_out, min_out, rise_cnt, fall_cnt, eq_cnt};

  // Frame statistics recomputed from scratch from the accepted-sample list.
  function automatic logic [2*W+3*CW+1:0] model();
    logic [W-1:0] mx, mn;
    logic [CW-1:0] r, f, e;
    mx = 0; mn = 0; r = 0; f = 0; e = 0;
    for (int i = 0; i < q.size(); i++) begin
      if (i == 0) begin
        mx = q[i]; mn = q[i];
      end else begin
        if (q[i] > mx) mx = q[i];
        if (q[i] < mn) mn = q[i];
        if (q[i] > q[i-1]) r++;
        else if (q[i] < q[i-1]) f++;
        else e++;
      end
    end
    return {m_done, !m_done, mx, mn, r, f, e};
  endfunction

  // One clock of stimulus; the model follows the handshake rules at that edge.
  task automatic cycle(input bit v, input logic [W-1:0] d, input bit c, input bit ordy);
    in_valid = v; in_data = d; clr = c; out_ready = ordy;
    @(posedge Clk);
    if (c) begin
      q.delete(); m_done = 0;
    end else if (m_done) begin
      if (ordy) begin q.delete(); m_done = 0; end
    end else if (v) begin
      q.push_back(d);
      if (q.size() == FL) m_done = 1;
    end
    #1;
    in_valid = 0; clr = 0; out_ready = 0; in_data = W'($urandom);
  endtask

  task automatic drain();
    while (!m_done) cycle(1, W'($urandom), 0, 0);
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_reset();
    #1 Rst = 0;
    q.delete(); m_done = 0;
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (obs !== {1'b0, 1'b1, {(2*W+3*CW){1'b0}}}) begin
      errors++; $display("FAIL reset: got %h expected %h", obs, {1'b0, 1'b1, {(2*W+3*CW){1'b0}}});
    end
    Rst = 1;
  endtask

  task automatic test_ramp();
    logic [W-1:0] d[4];
    d = '{8'd1, 8'd2, 8'd3, 8'd4};
    for (int i = 0; i < 4; i++) begin
      cycle(1, d[i], 0, 0);
      checks++;
      if (obs !== model()) begin
        errors++; $display("FAIL ramp step %0d: got %h expected %h", i, obs, model());
      end
    end
    checks++;
    if ({out_valid, in_ready, max_out, min_out, rise_cnt, fall_cnt, eq_cnt} !==
        {1'b1, 1'b0, 8'd4, 8'd1, 3'd3, 3'd0, 3'd0}) begin
      errors++; $display("FAIL ramp result: got %h", obs);
    end
    cycle(0, 0, 0, 1);
    checks++;
    if (obs !== model()) begin
      errors++; $display("FAIL ramp release: got %h expected %h", obs, model());
    end
  endtask

  task automatic test_extremes();
    logic [W-1:0] d[4];
    d = '{8'd255, 8'd0, 8'd0, 8'd128};
    for (int i = 0; i < 4; i++) cycle(1, d[i], 0, 0);
    checks++;
    if ({out_valid, max_out, min_out, rise_cnt, fall_cnt, eq_cnt} !==
        {1'b1, 8'd255, 8'd0, 3'd1, 3'd1, 3'd1}) begin
      errors++; $display("FAIL extremes result: got %h", obs);
    end
    cycle(0, 0, 0, 1);
    checks++;
    if (obs !== {1'b0, 1'b1, {(2*W+3*CW){1'b0}}}) begin
      errors++; $display("FAIL extremes release: got %h expected cleared", obs);
    end
  endtask

  task automatic test_hold_done();
    while (!m_done) cycle(1, W'($urandom), 0, 0);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 8'd9, 0, 0);
      checks++;
      if (obs !== model()) begin
        errors++; $display("FAIL hold_done cycle %0d: got %h expected %h", i, obs, model());
      end
    end
    cycle(1, 8'd9, 0, 1);
    checks++;
    if (obs !== model()) begin
      errors++; $display("FAIL hold_done handshake: got %h expected %h", obs, model());
    end
    cycle(1, 8'd9, 0, 0);
    checks++;
    if (obs !== model() || max_out !== 8'd9) begin
      errors++; $display("FAIL hold_done first sample: got %h expected %h", obs, model());
    end
    drain();
  endtask

  task automatic test_clr();
    cycle(1, 8'd5, 0, 0);
    cycle(1, 8'd7, 0, 0);
    cycle(1, 8'd200, 1, 0);
    checks++;
    if (obs !== model()) begin
      errors++; $display("FAIL clr abort: got %h expected %h", obs, model());
    end
    for (int i = 0; i < 4; i++) cycle(1, 8'd3, 0, 0);
    checks++;
    if ({out_valid, max_out, min_out, rise_cnt, fall_cnt, eq_cnt} !==
        {1'b1, 8'd3, 8'd3, 3'd0, 3'd0, 3'd3}) begin
      errors++; $display("FAIL clr next frame: got %h", obs);
    end
    cycle(0, 0, 1, 0);
    checks++;
    if (obs !== model()) begin
      errors++; $display("FAIL clr in done: got %h expected %h", obs, model());
    end
  endtask

  task automatic test_async_reset();
    logic [W-1:0] d[4];
    d = '{8'd10, 8'd8, 8'd12, 8'd6};
    cycle(1, W'($urandom), 0, 0);
    cycle(1, W'($urandom), 0, 0);
    #3 Rst = 0;
    q.delete(); m_done = 0;
    #1;
    checks++;
    if (obs !== model()) begin
      errors++; $display("FAIL async reset: got %h expected %h", obs, model());
    end
    #2 Rst = 1;
    @(posedge Clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("FAIL async release in_ready: got %b expected 1", in_ready);
    end
    for (int i = 0; i < 4; i++) cycle(1, d[i], 0, 0);
    checks++;
    if ({out_valid, max_out, min_out, rise_cnt, fall_cnt, eq_cnt} !==
        {1'b1, 8'd12, 8'd6, 3'd1, 3'd2, 3'd0}) begin
      errors++; $display("FAIL async next frame: got %h", obs);
    end
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_gaps();
    bit v[7];
    logic [W-1:0] d[7];
    v = '{1, 0, 0, 1, 0, 1, 1};
    d = '{8'd4, 8'd0, 8'd0, 8'd6, 8'd0, 8'd2, 8'd9};
    for (int i = 0; i < 7; i++) begin
      cycle(v[i], v[i] ? d[i] : W'($urandom), 0, 0);
      checks++;
      if (obs !== model()) begin
        errors++; $display("FAIL gaps step %0d: got %h expected %h", i, obs, model());
      end
    end
    cycle(0, 0, 0, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0,
            ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 3)) : W'($urandom),
            $urandom_range(0, 29) == 0,
            $urandom_range(0, 2) == 0);
      checks++;
      if (obs !== model()) begin
        errors++; $display("FAIL random cycle %0d: got %h expected %h", i, obs, model());
      end
    end
  endtask

  initial begin
    Rst = 1; clr = 0; in_valid = 0; in_data = 0; out_ready = 0;
    checks = 0; errors = 0; m_done = 0;
    test_reset();
    test_ramp();
    test_extremes();
    test_hold_done();
    test_clr();
    test_async_reset();
    test_gaps();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
